score_digits_gen: RTL

- Parametrised multi-digit seven-segment renderer for the VGA pixel path.
- Holds a BCD score counter. Renders NUM_DIGITS glyphs at a configurable screen position, in a configurable colour.
- Supports leading-zero blanking, a frame-synchronised blink mode and wrap/saturate overflow handling.
- Sits between the VGA timing generator (col, row, valid, frame_start) and the colour mux; game logic drives inc/clear.

---
 rtl/score_digits_gen_if.sv | 10 +
 rtl/score_digits_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/score_digits_gen_if.sv
// score_digits_gen_if: pixel timing, score control and render output of score_digits_gen.
interface score_digits_gen_if #(parameter int NUM_DIGITS = 2);
   logic [9:0] col, row;
   logic valid, frame_start, inc, clear, blink_en;
   logic [5:0] digit;
   logic [4*NUM_DIGITS-1:0] score;
   logic overflow;
   modport master (output col, row, valid, frame_start, inc, clear, blink_en, input digit, score, overflow);
   modport slave (input col, row, valid, frame_start, inc, clear, blink_en, output digit, score, overflow);
endinterface

// File: rtl/score_digits_gen.sv
// score_digits_gen: BCD score counter rendered as seven-segment glyphs on the VGA pixel stream.
module score_digits_gen #(
   parameter int NUM_DIGITS = 2,
   parameter logic [9:0] X0 = 10'd46,
   parameter logic [9:0] Y0 = 10'd70,
   parameter logic [9:0] SEG_LEN = 10'd15,
   parameter logic [9:0] SEG_W = 10'd10,
   parameter logic [9:0] GAP = 10'd8,
   parameter logic [5:0] COLOR = 6'b001100,
   parameter bit WRAP = 1'b1,
   parameter bit BLANK_LZ = 1'b1,
   parameter int BLINK_FRAMES = 30
) (
   input logic clk,
   input logic reset,
   score_digits_gen_if.slave bus
);
   localparam int ND = NUM_DIGITS;
   localparam int SL = int'(SEG_LEN);
   localparam int SW = int'(SEG_W);
   localparam int XB = int'(X0);
   localparam int YB = int'(Y0);
   localparam int W = SL + 2*SW;
   localparam int H = 2*SL + 3*SW;
   localparam int PITCH = W + int'(GAP);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   logic [4*ND-1:0] score_q, score_d;
   logic ovf_q, ovf_d, phase_q, phase_d, carry, all9, lit, lz, up, lo, lft, rgt, inx, bwrap;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [5:0] digit_q, digit_d;
   logic [3:0] nib;
   logic [6:0] sg;
   int c, r, x;
   // Segment bits abcdefg, a in bit 6.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0: return 7'b1111110;
         4'd1: return 7'b0110000;
         4'd2: return 7'b1101101;
         4'd3: return 7'b1111001;
         4'd4: return 7'b0110011;
         4'd5: return 7'b1011011;
         4'd6: return 7'b1011111;
         4'd7: return 7'b1110000;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction
   always_comb begin
      score_d = score_q;
      ovf_d = ovf_q;
      carry = 1'b1;
      all9 = 1'b1;
      for (int i = 0; i < ND; i++) all9 = all9 && score_q[4*i +: 4] == 4'd9;
      if (bus.clear) begin
         score_d = '0;
         ovf_d = 1'b0;
      end else if (bus.inc && all9) begin
         score_d = WRAP ? '0 : score_q;
         ovf_d = 1'b1;
      end else if (bus.inc) begin
         for (int i = 0; i < ND; i++) begin
            score_d[4*i +: 4] = !carry ? score_q[4*i +: 4] : score_q[4*i +: 4] == 4'd9 ? 4'd0 : score_q[4*i +: 4] + 4'd1;
            carry = carry && score_q[4*i +: 4] == 4'd9;
         end
      end
   end
   always_comb begin
      bwrap = bcnt_q == BW'(BLINK_FRAMES - 1);
      bcnt_d = !bus.blink_en ? '0 : !bus.frame_start ? bcnt_q : bwrap ? '0 : bcnt_q + 1'b1;
      phase_d = bus.blink_en && (phase_q ^ (bus.frame_start && bwrap));
   end
   always_comb begin
      lit = 1'b0;
      lz = 1'b1;
      nib = 4'd0;
      sg = 7'd0;
      x = 0;
      lft = 1'b0;
      rgt = 1'b0;
      inx = 1'b0;
      c = int'(bus.col);
      r = int'(bus.row);
      up = r >= YB && r < YB + 2*SW + SL;
      lo = r >= YB + SW + SL && r < YB + H;
      for (int i = 0; i < ND; i++) begin
         nib = score_q[4*(ND-1-i) +: 4];
         lz = lz && nib == 4'd0;
         sg = seg7(nib);
         x = XB + i*PITCH;
         inx = c >= x && c < x + W;
         lft = c >= x && c < x + SW;
         rgt = c >= x + W - SW && c < x + W;
         lit = lit || (!(BLANK_LZ && lz && i != ND - 1) &&
            ((sg[6] && inx && r >= YB && r < YB + SW) ||
             (sg[5] && rgt && up) || (sg[4] && rgt && lo) ||
             (sg[3] && inx && r >= YB + H - SW && r < YB + H) ||
             (sg[2] && lft && lo) || (sg[1] && lft && up) ||
             (sg[0] && inx && r >= YB + SW + SL && r < YB + 2*SW + SL)));
      end
      digit_d = bus.valid && lit && !(bus.blink_en && phase_q) ? COLOR : 6'd0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score_q <= '0;
         ovf_q <= 1'b0;
         bcnt_q <= '0;
         phase_q <= 1'b0;
         digit_q <= 6'd0;
      end else begin
         score_q <= score_d;
         ovf_q <= ovf_d;
         bcnt_q <= bcnt_d;
         phase_q <= phase_d;
         digit_q <= digit_d;
      end
   end
   assign bus.digit = digit_q;
   assign bus.score = score_q;
   assign bus.overflow = ovf_q;
endmodule
